// File: rtl/pll_reset_sequencer.sv
// Brings the ECP5 memory-clock PLL out of reset, qualifies lock, releases the
// memory and CPU resets in order, and sequences dynamic phase-step requests.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int RELOCK_TIMEOUT     = 65535,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 16,
  parameter int PULSE_CYCLES       = 4,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pll_locked,
  output logic       pll_rst,
  input  logic       phase_req,
  input  logic [1:0] phase_sel,
  input  logic       phase_dir,
  output logic       phase_ack,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       pll_phaseloadreg,
  output logic       rst_mem_n,
  output logic       rst_cpu_n,
  output logic [2:0] state,
  output logic [7:0] lock_lost_count,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILISE = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_PHASE     = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int TO_W  = $clog2(RELOCK_TIMEOUT + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int STG_W = $clog2(STAGGER_CYCLES + 1);
  localparam int PH_W  = $clog2(2 * PULSE_CYCLES + 2);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0] RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(RELOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST    = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST    = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LOW_LAST = PH_W'(PULSE_CYCLES);
  localparam logic [PH_W-1:0]  PH_ACK      = PH_W'(2 * PULSE_CYCLES + 1);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic             lk_meta_q, lk_q;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [STG_W-1:0] stg_cnt_q, stg_cnt_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic [RTY_W-1:0] retries_q, retries_d;
  logic [7:0]       lost_q, lost_d;
  logic [1:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic             armed_q, armed_d;
  logic             lock_loss;
  logic             ack_now;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_RESET_PLL;
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stb_cnt_q <= '0;
      stg_cnt_q <= '0;
      ph_cnt_q  <= '0;
      retries_q <= '0;
      lost_q    <= '0;
      sel_q     <= 2'd0;
      dir_q     <= 1'b1;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      lk_meta_q <= pll_locked;
      lk_q      <= lk_meta_q;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      stg_cnt_q <= stg_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      retries_q <= retries_d;
      lost_q    <= lost_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      armed_q   <= armed_d;
    end
  end

  assign ack_now = (state_q == S_PHASE) && lk_q && (ph_cnt_q == PH_ACK);

  // Counters only advance while their own state persists, so each starts at zero on entry.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    to_cnt_d  = '0;
    stb_cnt_d = '0;
    stg_cnt_d = '0;
    ph_cnt_d  = '0;
    retries_d = retries_q;
    lost_d    = lost_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    lock_loss = 1'b0;
    // A request must be seen low after its ack before another step can start.
    armed_d   = ack_now ? 1'b0 : (armed_q | ~phase_req);

    case (state_q)
      S_RESET_PLL: begin
        if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      S_WAIT_LOCK: begin
        if (lk_q) begin
          state_d = S_STABILISE;
        end else if (to_cnt_q == TO_LAST) begin
          retries_d = retries_q + RTY_W'(1);
          state_d   = (retries_q + RTY_W'(1) == RTY_MAX) ? S_FAULT : S_RESET_PLL;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_STABILISE: begin
        if (!lk_q)                     state_d = S_WAIT_LOCK;
        else if (stb_cnt_q == STB_LAST) state_d = S_RELEASE;
        else                           stb_cnt_d = stb_cnt_q + STB_W'(1);
      end
      S_RELEASE: begin
        if (!lk_q) begin
          lock_loss = 1'b1;
        end else if (stg_cnt_q == STG_LAST) begin
          state_d   = S_RUN;
          retries_d = '0;
        end else begin
          stg_cnt_d = stg_cnt_q + STG_W'(1);
        end
      end
      S_RUN: begin
        if (!lk_q) begin
          lock_loss = 1'b1;
        end else if (phase_req && armed_q) begin
          state_d = S_PHASE;
          sel_d   = phase_sel;
          dir_d   = phase_dir;
        end
      end
      S_PHASE: begin
        if (!lk_q)                  lock_loss = 1'b1;
        else if (ph_cnt_q == PH_ACK) state_d = S_RUN;
        else                        ph_cnt_d = ph_cnt_q + PH_W'(1);
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RESET_PLL;
    endcase

    if (lock_loss) begin
      state_d = S_RESET_PLL;
      lost_d  = (lost_q == 8'hFF) ? 8'hFF : lost_q + 8'd1;
    end
  end

  // Step pulse is gated by lk so a lock drop mid-step releases PHASESTEP at once.
  always_comb begin
    pll_rst          = (state_q == S_RESET_PLL);
    rst_mem_n        = (state_q == S_RELEASE) || (state_q == S_RUN) || (state_q == S_PHASE);
    rst_cpu_n        = (state_q == S_RUN) || (state_q == S_PHASE);
    fault            = (state_q == S_FAULT);
    phase_ack        = ack_now;
    pll_phasestep    = !((state_q == S_PHASE) && lk_q &&
                         (ph_cnt_q != '0) && (ph_cnt_q <= PH_LOW_LAST));
    pll_phaseloadreg = 1'b1;
    pll_phasesel     = sel_q;
    pll_phasedir     = dir_q;
    state            = state_q;
    lock_lost_count  = lost_q;
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed bring-up, glitch, fault, phase and
// async-reset cases plus randomized phase steps and lock drops against a timeline model.
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_TO  = 20;
  localparam int P_STB = 8;
  localparam int P_STG = 3;
  localparam int P_PUL = 2;
  localparam int P_RTY = 2;

  localparam logic [20:0] RESET_VEC =
    {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'd0};

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       phase_req = 1'b0;
  logic [1:0] phase_sel = 2'd0;
  logic       phase_dir = 1'b0;
  logic       phase_ack;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
  logic       pll_phaseloadreg;
  logic       rst_mem_n;
  logic       rst_cpu_n;
  logic [2:0] state;
  logic [7:0] lock_lost_count;
  logic       fault;
  logic [20:0] out_vec;

  int checks = 0;
  int failures = 0;
  int tb_cyc = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST), .RELOCK_TIMEOUT(P_TO), .LOCK_STABLE_CYCLES(P_STB),
    .STAGGER_CYCLES(P_STG), .PULSE_CYCLES(P_PUL), .MAX_RETRIES(P_RTY)
  ) dut (
    .clock(clock), .resetn(resetn), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .phase_req(phase_req), .phase_sel(phase_sel), .phase_dir(phase_dir),
    .phase_ack(phase_ack), .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep), .pll_phaseloadreg(pll_phaseloadreg),
    .rst_mem_n(rst_mem_n), .rst_cpu_n(rst_cpu_n), .state(state),
    .lock_lost_count(lock_lost_count), .fault(fault)
  );

  always #5 clock = ~clock;

  assign out_vec = {state, pll_rst, rst_mem_n, rst_cpu_n, fault, phase_ack, pll_phasesel,
                    pll_phasedir, pll_phasestep, pll_phaseloadreg, lock_lost_count};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Timeline model: mode number, the cycle it was entered, and the lock history.
  int         m_mode = 0, m_enter = 0, m_cyc = 0, m_retries = 0, m_lost = 0;
  int         m_age, m_next;
  logic [1:0] m_sel = 2'd0;
  logic       m_dir = 1'b1;
  bit         m_armed = 1'b1, m_h1 = 1'b0, m_h2 = 1'b0, m_lk, m_ack;

  task automatic modelStep();
    if (!resetn) begin
      m_mode = 0; m_enter = 0; m_cyc = 0; m_retries = 0; m_lost = 0;
      m_sel = 2'd0; m_dir = 1'b1; m_armed = 1'b1; m_h1 = 1'b0; m_h2 = 1'b0;
      return;
    end
    m_age  = m_cyc - m_enter;
    m_lk   = m_h2;
    m_next = m_mode;
    m_ack  = (m_mode == 5) && m_lk && (m_age == 2 * P_PUL + 1);
    case (m_mode)
      0: if (m_age + 1 == P_RST) m_next = 1;
      1: if (m_lk) m_next = 2;
         else if (m_age + 1 == P_TO) begin
           m_retries++;
           m_next = (m_retries == P_RTY) ? 6 : 0;
         end
      2: if (!m_lk) m_next = 1; else if (m_age + 1 == P_STB) m_next = 3;
      3: if (!m_lk) m_next = -1;
         else if (m_age + 1 == P_STG) begin m_next = 4; m_retries = 0; end
      4: if (!m_lk) m_next = -1;
         else if (phase_req && m_armed) begin
           m_next = 5; m_sel = phase_sel; m_dir = phase_dir;
         end
      5: if (!m_lk) m_next = -1; else if (m_ack) m_next = 4;
      default: ;
    endcase
    m_armed = m_ack ? 1'b0 : (m_armed | !phase_req);
    if (m_next == -1) begin
      m_lost = (m_lost < 255) ? m_lost + 1 : 255;
      m_next = 0;
    end
    if (m_next != m_mode) m_enter = m_cyc + 1;
    m_mode = m_next;
    m_cyc++;
    m_h2 = m_h1;
    m_h1 = pll_locked;
  endtask

  function automatic logic [20:0] modelOutputs();
    int   age;
    logic ack, step;
    age  = m_cyc - m_enter;
    ack  = (m_mode == 5) && m_h2 && (age == 2 * P_PUL + 1);
    step = !((m_mode == 5) && m_h2 && (age >= 1) && (age <= P_PUL));
    return {3'(m_mode), 1'(m_mode == 0), 1'(m_mode inside {3, 4, 5}),
            1'(m_mode inside {4, 5}), 1'(m_mode == 6), ack, m_sel, m_dir, step,
            1'b1, 8'(m_lost)};
  endfunction

  initial forever begin
    @(posedge clock or negedge resetn);
    modelStep();
  end

  initial forever begin
    @(negedge clock);
    checkOutput($sformatf("outs_c%0d_m%0d", m_cyc, m_mode), out_vec, modelOutputs());
  end

  task automatic tick();
    @(posedge clock);
    #1;
    tb_cyc++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic waitCycle(input int c);
    while (tb_cyc < c) tick();
  endtask

  task automatic applyStimulus(input logic req, input logic [1:0] sel, input logic dir,
                               input logic locked);
    phase_req  = req;
    phase_sel  = sel;
    phase_dir  = dir;
    pll_locked = locked;
  endtask

  // Holds reset for two edges, checks reset values, releases so the current cycle is 0.
  task automatic applyReset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_vals", out_vec, RESET_VEC);
    resetn = 1'b1;
    tb_cyc = 0;
  endtask

  task automatic waitState(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin tick(); n++; end
    checkOutput(tag, state, s);
  endtask

  task automatic waitAck(input int budget, input string tag);
    int n = 0;
    while (phase_ack !== 1'b1 && n < budget) begin tick(); n++; end
    checkOutput(tag, phase_ack, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         losses;
    int         act, len, k;
    logic [1:0] sel;
    logic       dir;

    // Clean bring-up, lock raised at cycle 10: lk at 12, STABILISE 13..20.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    applyReset();
    waitCycle(3);  checkOutput("up_pll_rst_c3", pll_rst, 1'b1);
    waitCycle(4);  checkOutput("up_pll_rst_c4", pll_rst, 1'b0);
                   checkOutput("up_state_c4", state, 3'd1);
    waitCycle(10); applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    waitCycle(20); checkOutput("up_mem_c20", rst_mem_n, 1'b0);
    waitCycle(21); checkOutput("up_mem_c21", rst_mem_n, 1'b1);
                   checkOutput("up_cpu_c21", rst_cpu_n, 1'b0);
    waitCycle(23); checkOutput("up_cpu_c23", rst_cpu_n, 1'b0);
    waitCycle(24); checkOutput("up_cpu_c24", rst_cpu_n, 1'b1);
                   checkOutput("up_state_c24", state, 3'd4);

    // Directed phase step: sel=2, lead.
    waitCycle(26); applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
    waitCycle(27); checkOutput("ph_seldir", {pll_phasesel, pll_phasedir}, 3'b100);
                   checkOutput("ph_step_c27", pll_phasestep, 1'b1);
    waitCycle(28); checkOutput("ph_step_c28", pll_phasestep, 1'b0);
    waitCycle(29); checkOutput("ph_step_c29", pll_phasestep, 1'b0);
    waitCycle(30); checkOutput("ph_step_c30", pll_phasestep, 1'b1);
    waitCycle(31); checkOutput("ph_ack_c31", phase_ack, 1'b0);
    waitCycle(32); checkOutput("ph_ack_c32", phase_ack, 1'b1);
    waitCycle(33); applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);
                   checkOutput("ph_ack_c33", phase_ack, 1'b0);
    waitCycle(38); checkOutput("ph_single_step", state, 3'd4);

    // Lock loss in RUN at cycle 40: lk low at 42, resets drop at 43.
    waitCycle(40); applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    waitCycle(42); checkOutput("loss_mem_c42", rst_mem_n, 1'b1);
    waitCycle(43); checkOutput("loss_mem_c43", rst_mem_n, 1'b0);
                   checkOutput("loss_count", lock_lost_count, 8'd1);

    // Glitchy lock: high 6..10, low 11, high from 12.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    applyReset();
    waitCycle(6);  applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    waitCycle(11); applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    waitCycle(12); applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
                   checkOutput("gl_state_c12", state, 3'd2);
    waitCycle(14); checkOutput("gl_state_c14", state, 3'd1);
    waitCycle(15); checkOutput("gl_state_c15", state, 3'd2);
    waitCycle(22); checkOutput("gl_mem_c22", rst_mem_n, 1'b0);
    waitCycle(23); checkOutput("gl_mem_c23", rst_mem_n, 1'b1);
    waitCycle(26); checkOutput("gl_state_c26", state, 3'd4);

    // Timeout to fault with lock never seen.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    applyReset();
    waitCycle(23); checkOutput("to_state_c23", state, 3'd1);
    waitCycle(24); checkOutput("to_pll_rst_c24", pll_rst, 1'b1);
    waitCycle(28); checkOutput("to_pll_rst_c28", pll_rst, 1'b0);
    waitCycle(47); checkOutput("to_state_c47", state, 3'd1);
    waitCycle(48); checkOutput("to_state_c48", state, 3'd6);
                   checkOutput("to_fault", {fault, pll_rst, rst_mem_n, rst_cpu_n}, 4'b1000);
    waitCycle(50); applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
    waitCycle(70); checkOutput("to_stuck", state, 3'd6);

    // Async reset in RELEASE (13..15 with lock held high), then a fresh bring-up.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyReset();
    waitCycle(14); checkOutput("ar_state_c14", state, 3'd3);
    #2 resetn = 1'b0;
    #1 checkOutput("ar_async_vals", out_vec, RESET_VEC);
    applyReset();
    waitCycle(12); checkOutput("ar_state_c12", state, 3'd2);
    waitCycle(15); checkOutput("ar_state_c15", state, 3'd3);
    waitCycle(16); checkOutput("ar_state_c16", state, 3'd4);

    // Randomized phase steps, RUN lock drops and lock drops during PHASE.
    losses = 0;
    for (int i = 0; i < 24; i++) begin
      act = $urandom_range(0, 2);
      sel = 2'($urandom_range(0, 3));
      dir = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3);
      k   = $urandom_range(1, 4);
      if (act == 0) begin
        applyStimulus(1'b1, sel, dir, 1'b1);
        waitAck(20, "rnd_ack");
        checkOutput("rnd_seldir", {pll_phasesel, pll_phasedir}, {sel, dir});
        tick();
        applyStimulus(1'b0, sel, dir, 1'b1);
      end else if (act == 1) begin
        applyStimulus(1'b0, sel, dir, 1'b0);
        ticks(len);
        applyStimulus(1'b0, sel, dir, 1'b1);
        ticks(4);
        losses++;
        waitState(3'd4, 120, "rnd_relock");
      end else begin
        applyStimulus(1'b1, sel, dir, 1'b1);
        ticks(k);
        applyStimulus(1'b1, sel, dir, 1'b0);
        ticks(len);
        applyStimulus(1'b1, sel, dir, 1'b1);
        losses++;
        waitAck(200, "rnd_ack_after_loss");
        tick();
        applyStimulus(1'b0, sel, dir, 1'b1);
      end
      checkOutput("rnd_lost_count", lock_lost_count, 8'(losses));
      ticks($urandom_range(1, 3));
      waitState(3'd4, 120, "rnd_run");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
